board_event_checker: RTL and testbench
======================================

BOARD_EVENT_CHECKER -- requirements
Module: board_event_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 65, giving the event word width; bit DATA_WIDTH-1 is the control flag.
REQ-002 SHALL have parameter CHK_ID, default 0, giving the instance identifier reported on chk_id.
REQ-003 SHALL have port b2b_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port b2b_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_event, input, DATA_WIDTH bits: merged board event word from the upstream FIFO.
REQ-006 SHALL have port in_req, output, 1 bit: FIFO read request.
REQ-007 SHALL have port in_empty, input, 1 bit: FIFO empty.
REQ-008 SHALL have port out_event, output, DATA_WIDTH bits: forwarded event word.
REQ-009 SHALL have port out_wren, output, 1 bit: write enable for out_event.
REQ-010 SHALL have port out_almost_full, input, 1 bit: downstream backpressure.
REQ-011 SHALL have port err_meta, output, 1 bit: one-cycle pulse when the footer meta count mismatches.
REQ-012 SHALL have port err_word, output, 1 bit: one-cycle pulse when the footer word count mismatches.
REQ-013 SHALL have port err_crc, output, 1 bit: one-cycle pulse when the footer CRC is not 32'hdeadbeef.
REQ-014 SHALL have port err_seq, output, 1 bit: one-cycle pulse on a framing violation.
REQ-015 SHALL have port evt_count, output, 32 bits: number of completed events.
REQ-016 SHALL have port err_count, output, 16 bits: number of events with any error, saturating.
REQ-017 SHALL have port last_l0id, output, EVT_HDR_W1_L0ID_bits bits: L0ID of the most recent header.
REQ-018 SHALL have port chk_id, output, 8 bits: equal to CHK_ID.

Function
REQ-019 in_req SHALL be !in_empty && !out_almost_full && !b2b_rst; a word is valid the cycle after in_req is high.
REQ-020 Every valid word SHALL appear unmodified on out_event, with out_wren high, exactly 1 cycle after it is valid, except the dropped words in REQ-024.
REQ-021 Word classes: a header is a ctrl word whose EVT_HDR_W1_FLAG field equals EVT_HDR_W1_FLAG_FLAG; a footer W1 is a ctrl word whose EVT_FTR_W1_FLAG field equals EVT_FTR_W1_FLAG_FLAG; any other ctrl word is a meta word.
REQ-022 FSM states SHALL be IDLE, BODY, FTR2 and FTR3; state advances only on valid words.
REQ-023 On a header in IDLE: go to BODY, set meta_cnt=1 and word_cnt=1, and latch last_l0id from EVT_HDR_W1_L0ID.
REQ-024 On a non-header word in IDLE: drop it (no out_wren), pulse err_seq, and stay in IDLE.
REQ-025 In BODY, a meta word SHALL increment meta_cnt and word_cnt.
REQ-026 In BODY, a non-ctrl word SHALL increment word_cnt.
REQ-027 In BODY, a footer W1 SHALL compare EVT_FTR_W1_META_COUNT with meta_cnt (truncated to field width), latch the result, and go to FTR2.
REQ-028 In BODY, a header SHALL pulse err_seq, increment err_count, forward the word, restart the counts per REQ-023, and stay in BODY.
REQ-029 In FTR2, any word SHALL go to FTR3.
REQ-030 In FTR3, the word SHALL be checked against EVT_FTR_W3_WORD_COUNT vs word_cnt (field width) and EVT_FTR_W3_CRC vs 32'hdeadbeef; then go to IDLE.
REQ-031 err_meta, err_word and err_crc SHALL pulse together in the same cycle that footer W3 appears on out_event.
REQ-032 In that same cycle evt_count SHALL increment, wrapping at 2^32; err_count SHALL increment once if any error is set, saturating at 16'hFFFF.
REQ-033 A ctrl word arriving in FTR2 or FTR3 SHALL pulse err_seq and still be treated as a footer word.
REQ-034 word_cnt SHALL be 32 bits and meta_cnt 16 bits, both saturating.
REQ-035 Asserting out_almost_full mid-event SHALL only stall; no word is lost or duplicated, and the word read in the cycle in_req falls is still forwarded.

Reset
REQ-036 While b2b_rst is high: out_event=0, out_wren=0, all err_* = 0, evt_count=0, err_count=0, last_l0id=0, counts=0, FSM=IDLE, and in_req=0.
REQ-037 Reset mid-event SHALL abandon the partial event with no error pulse; the first word after reset is handled from IDLE.

Structure
REQ-038 Flag, field and width constants SHALL come from TP_DataFormat; the FSM state enum and the CRC constant 32'hdeadbeef SHALL go in the shared b2b package.
REQ-039 The block SHALL be a single flat module with no sub-modules.

Verification
REQ-040 A clean event (header L0ID=0x123, 2 meta words, 5 data words, footer meta=3, word count=8, CRC=deadbeef) SHALL be forwarded with 1-cycle latency, raise no err_* pulse, give evt_count=1, and set last_l0id=0x123.
REQ-041 The same event with footer meta=4 and word count=9 SHALL pulse err_meta and err_word on the W3 cycle, give err_count=1, and not pulse err_crc.
REQ-042 An event with CRC=0 SHALL pulse err_crc only.
REQ-043 Two data words before any header SHALL both be dropped and give 2 err_seq pulses; the following clean event SHALL pass.
REQ-044 A header in mid-body SHALL pulse err_seq once; the second event SHALL check clean with its counts restarted.
REQ-045 Toggling out_almost_full every 3 cycles and pulsing b2b_rst mid-event SHALL produce an output stream equal to the input stream with no loss, and after reset all outputs SHALL be 0 and the next event SHALL be checked clean.

Source files
------------

// File: rtl/TP_DataFormat.sv
// -----------------------------------------------------------------------------
// TP_DataFormat
// Bit layout of the merged board event word: the control flag, the header and
// footer flag fields, and the header/footer payload fields.
// Word layout: bit 64 is the control flag and bits 63:0 are the payload.
// No ports (package).
// -----------------------------------------------------------------------------
package TP_DataFormat;

    localparam int EVT_WORD_W = 65;

    // Header word 1
    localparam int         EVT_HDR_W1_FLAG_msb  = 63;
    localparam int         EVT_HDR_W1_FLAG_lsb  = 56;
    localparam logic [7:0] EVT_HDR_W1_FLAG_FLAG = 8'hAB;
    localparam int         EVT_HDR_W1_L0ID_msb  = 39;
    localparam int         EVT_HDR_W1_L0ID_lsb  = 0;
    localparam int         EVT_HDR_W1_L0ID_bits = 40;

    // Footer word 1
    localparam int         EVT_FTR_W1_FLAG_msb       = 63;
    localparam int         EVT_FTR_W1_FLAG_lsb       = 56;
    localparam logic [7:0] EVT_FTR_W1_FLAG_FLAG      = 8'hCD;
    localparam int         EVT_FTR_W1_META_COUNT_msb = 15;
    localparam int         EVT_FTR_W1_META_COUNT_lsb = 0;

    // Footer word 3
    localparam int EVT_FTR_W3_WORD_COUNT_msb = 63;
    localparam int EVT_FTR_W3_WORD_COUNT_lsb = 32;
    localparam int EVT_FTR_W3_CRC_msb        = 31;
    localparam int EVT_FTR_W3_CRC_lsb        = 0;

endpackage

// File: rtl/b2b_pkg.sv
// -----------------------------------------------------------------------------
// b2b_pkg
// Shared board-to-board definitions: the event checker FSM state type and the
// fixed footer CRC value.
// No ports (package).
// -----------------------------------------------------------------------------
package b2b_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        FTR2,
        FTR3
    } chk_state_e;

    localparam logic [31:0] B2B_FTR_CRC = 32'hdeadbeef;

endpackage

// File: rtl/board_event_checker.sv
// -----------------------------------------------------------------------------
// board_event_checker
// Reads merged board event words from an upstream FIFO, forwards them one cycle
// after they are valid, and checks event framing plus the footer meta count,
// word count and CRC.
// Ports:
//   b2b_clk, b2b_rst          clock, synchronous active-high reset
//   in_event/in_req/in_empty  upstream FIFO read side (word valid 1 cycle after req)
//   out_event/out_wren        forwarded word and its write enable
//   out_almost_full           downstream backpressure (stalls reads)
//   err_meta/word/crc/seq     one-cycle error pulses aligned to out_event
//   evt_count/err_count       completed events / events with errors (saturating)
//   last_l0id                 L0ID of the most recent header
//   chk_id                    instance identifier
// -----------------------------------------------------------------------------
module board_event_checker
    import TP_DataFormat::*;
    import b2b_pkg::*;
#(
    parameter int DATA_WIDTH = 65,
    parameter int CHK_ID     = 0
) (
    input  logic                            b2b_clk,
    input  logic                            b2b_rst,
    input  logic [DATA_WIDTH-1:0]           in_event,
    output logic                            in_req,
    input  logic                            in_empty,
    output logic [DATA_WIDTH-1:0]           out_event,
    output logic                            out_wren,
    input  logic                            out_almost_full,
    output logic                            err_meta,
    output logic                            err_word,
    output logic                            err_crc,
    output logic                            err_seq,
    output logic [31:0]                     evt_count,
    output logic [15:0]                     err_count,
    output logic [EVT_HDR_W1_L0ID_bits-1:0] last_l0id,
    output logic [7:0]                      chk_id
);

    chk_state_e                      state_q, state_d;
    logic                            valid_q;
    logic [15:0]                     meta_cnt_q, meta_cnt_d;
    logic [31:0]                     word_cnt_q, word_cnt_d;
    logic                            meta_bad_q, meta_bad_d;
    logic [EVT_HDR_W1_L0ID_bits-1:0] l0id_q, l0id_d;
    logic [31:0]                     evt_cnt_q, evt_cnt_d;
    logic [15:0]                     err_cnt_q, err_cnt_d;
    logic [DATA_WIDTH-1:0]           out_event_q;
    logic                            out_wren_q;
    logic                            err_meta_q, err_word_q, err_crc_q, err_seq_q;
    logic                            fwd_d, seq_d, em_d, ew_d, ec_d, err_inc;

    // Word decode
    logic                            is_ctrl, is_hdr, is_ftr1;
    logic [EVT_HDR_W1_L0ID_bits-1:0] hdr_l0id;
    logic [15:0]                     ftr_meta;
    logic [31:0]                     ftr_wc, ftr_crc;

    assign is_ctrl  = in_event[DATA_WIDTH-1];
    assign is_hdr   = is_ctrl &&
                      (in_event[EVT_HDR_W1_FLAG_msb:EVT_HDR_W1_FLAG_lsb] == EVT_HDR_W1_FLAG_FLAG);
    assign is_ftr1  = is_ctrl &&
                      (in_event[EVT_FTR_W1_FLAG_msb:EVT_FTR_W1_FLAG_lsb] == EVT_FTR_W1_FLAG_FLAG);
    assign hdr_l0id = in_event[EVT_HDR_W1_L0ID_msb:EVT_HDR_W1_L0ID_lsb];
    assign ftr_meta = in_event[EVT_FTR_W1_META_COUNT_msb:EVT_FTR_W1_META_COUNT_lsb];
    assign ftr_wc   = in_event[EVT_FTR_W3_WORD_COUNT_msb:EVT_FTR_W3_WORD_COUNT_lsb];
    assign ftr_crc  = in_event[EVT_FTR_W3_CRC_msb:EVT_FTR_W3_CRC_lsb];

    assign in_req = !in_empty && !out_almost_full && !b2b_rst;

    always_comb begin
        state_d    = state_q;
        meta_cnt_d = meta_cnt_q;
        word_cnt_d = word_cnt_q;
        meta_bad_d = meta_bad_q;
        l0id_d     = l0id_q;
        evt_cnt_d  = evt_cnt_q;
        err_cnt_d  = err_cnt_q;
        fwd_d      = valid_q;
        seq_d      = 1'b0;
        em_d       = 1'b0;
        ew_d       = 1'b0;
        ec_d       = 1'b0;
        err_inc    = 1'b0;

        if (valid_q) begin
            unique case (state_q)
                IDLE: begin
                    if (is_hdr) begin
                        state_d    = BODY;
                        meta_cnt_d = 16'd1;
                        word_cnt_d = 32'd1;
                        l0id_d     = hdr_l0id;
                    end else begin
                        fwd_d = 1'b0;
                        seq_d = 1'b1;
                    end
                end
                BODY: begin
                    if (is_hdr) begin
                        // Unterminated event: the new header still opens an event.
                        seq_d      = 1'b1;
                        err_inc    = 1'b1;
                        meta_cnt_d = 16'd1;
                        word_cnt_d = 32'd1;
                        l0id_d     = hdr_l0id;
                    end else if (is_ftr1) begin
                        // Meta result is held until W3 so all footer errors pulse together.
                        meta_bad_d = (ftr_meta != meta_cnt_q);
                        state_d    = FTR2;
                    end else begin
                        if (is_ctrl && (meta_cnt_q != '1)) begin
                            meta_cnt_d = meta_cnt_q + 16'd1;
                        end
                        if (word_cnt_q != '1) begin
                            word_cnt_d = word_cnt_q + 32'd1;
                        end
                    end
                end
                FTR2: begin
                    seq_d   = is_ctrl;
                    state_d = FTR3;
                end
                FTR3: begin
                    seq_d     = is_ctrl;
                    em_d      = meta_bad_q;
                    ew_d      = (ftr_wc != word_cnt_q);
                    ec_d      = (ftr_crc != B2B_FTR_CRC);
                    evt_cnt_d = evt_cnt_q + 32'd1;
                    err_inc   = em_d || ew_d || ec_d;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge b2b_clk) begin
        if (b2b_rst) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            meta_cnt_q  <= '0;
            word_cnt_q  <= '0;
            meta_bad_q  <= 1'b0;
            l0id_q      <= '0;
            evt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            out_event_q <= '0;
            out_wren_q  <= 1'b0;
            err_meta_q  <= 1'b0;
            err_word_q  <= 1'b0;
            err_crc_q   <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= in_req;
            meta_cnt_q <= meta_cnt_d;
            word_cnt_q <= word_cnt_d;
            meta_bad_q <= meta_bad_d;
            l0id_q     <= l0id_d;
            evt_cnt_q  <= evt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            out_wren_q <= fwd_d;
            if (fwd_d) begin
                out_event_q <= in_event;
            end
            err_meta_q <= em_d;
            err_word_q <= ew_d;
            err_crc_q  <= ec_d;
            err_seq_q  <= seq_d;
        end
    end

    assign out_event = out_event_q;
    assign out_wren  = out_wren_q;
    assign err_meta  = err_meta_q;
    assign err_word  = err_word_q;
    assign err_crc   = err_crc_q;
    assign err_seq   = err_seq_q;
    assign evt_count = evt_cnt_q;
    assign err_count = err_cnt_q;
    assign last_l0id = l0id_q;
    assign chk_id    = 8'(CHK_ID);

endmodule

// File: tb/tb_board_event_checker.sv
module tb_board_event_checker;
    import TP_DataFormat::*;

    localparam int          DW       = 65;
    localparam logic [31:0] GOOD_CRC = 32'hdeadbeef;
    localparam int unsigned TMO      = 3000;

    typedef struct packed {
        logic [DW-1:0] w;
        logic          em;
        logic          ew;
        logic          ec;
        logic          seq;
        logic [31:0]   evt;
        logic [15:0]   errc;
    } rec_t;

    logic          clk;
    logic          b2b_rst;
    logic [DW-1:0] in_event;
    logic          in_req;
    logic          in_empty;
    logic [DW-1:0] out_event;
    logic          out_wren;
    logic          out_almost_full;
    logic          err_meta, err_word, err_crc, err_seq;
    logic [31:0]   evt_count;
    logic [15:0]   err_count;
    logic [39:0]   last_l0id;
    logic [7:0]    chk_id;

    board_event_checker #(
        .DATA_WIDTH (DW),
        .CHK_ID     (90)
    ) dut (
        .b2b_clk         (clk),
        .b2b_rst         (b2b_rst),
        .in_event        (in_event),
        .in_req          (in_req),
        .in_empty        (in_empty),
        .out_event       (out_event),
        .out_wren        (out_wren),
        .out_almost_full (out_almost_full),
        .err_meta        (err_meta),
        .err_word        (err_word),
        .err_crc         (err_crc),
        .err_seq         (err_seq),
        .evt_count       (evt_count),
        .err_count       (err_count),
        .last_l0id       (last_l0id),
        .chk_id          (chk_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO, monitor and backpressure generator
    logic [DW-1:0] src_q[$];
    int unsigned   pop_cyc_q[$];
    rec_t          obs_q[$];
    int unsigned   obs_cyc_q[$];
    rec_t          exp_q[$];
    int unsigned   cyc = 0;
    int            drop_seq = 0;
    int            stray_err = 0;
    bit            af_toggle_en = 1'b0;
    int            af_cnt = 0;

    // Reference bookkeeping
    int            checks = 0;
    int            errors = 0;
    int            drop_base, stray_base, exp_drop;
    logic [31:0]   exp_evt = '0;
    logic [15:0]   exp_errc = '0;
    logic [39:0]   exp_l0id = '0;

    initial begin
        in_event = '0;
        in_empty = 1'b1;
        out_almost_full = 1'b0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_req && src_q.size() > 0) begin
            in_event <= src_q.pop_front();
            pop_cyc_q.push_back(cyc + 1);
        end
    end

    always @(negedge clk) in_empty <= (src_q.size() == 0);

    always @(negedge clk) begin
        if (af_toggle_en) begin
            if (af_cnt == 2) begin
                af_cnt <= 0;
                out_almost_full <= ~out_almost_full;
            end else begin
                af_cnt <= af_cnt + 1;
            end
        end else begin
            af_cnt <= 0;
            out_almost_full <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (out_wren) begin
            obs_q.push_back('{w: out_event, em: err_meta, ew: err_word, ec: err_crc,
                              seq: err_seq, evt: evt_count, errc: err_count});
            obs_cyc_q.push_back(cyc);
        end else begin
            if (err_seq) drop_seq <= drop_seq + 1;
            if (err_meta || err_word || err_crc) stray_err <= stray_err + 1;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus builders ----------------
    function automatic logic [DW-1:0] rnd_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mk_data();
        logic [DW-1:0] w;
        w = rnd_word();
        w[DW-1] = 1'b0;
        return w;
    endfunction

    function automatic logic [DW-1:0] mk_meta();
        logic [DW-1:0] w;
        w = rnd_word();
        w[DW-1] = 1'b1;
        if (w[63:56] == EVT_HDR_W1_FLAG_FLAG || w[63:56] == EVT_FTR_W1_FLAG_FLAG) w[63:56] = 8'h11;
        return w;
    endfunction

    function automatic logic [DW-1:0] mk_hdr(input logic [39:0] l0id);
        logic [DW-1:0] w;
        w = rnd_word();
        w[DW-1] = 1'b1;
        w[63:56] = EVT_HDR_W1_FLAG_FLAG;
        w[39:0] = l0id;
        return w;
    endfunction

    function automatic logic [DW-1:0] mk_ftr1(input logic [15:0] meta);
        logic [DW-1:0] w;
        w = rnd_word();
        w[DW-1] = 1'b1;
        w[63:56] = EVT_FTR_W1_FLAG_FLAG;
        w[15:0] = meta;
        return w;
    endfunction

    function automatic logic [DW-1:0] mk_ftr3(input logic [31:0] wc, input logic [31:0] crc);
        logic [DW-1:0] w;
        w = '0;
        w[63:32] = wc;
        w[31:0] = crc;
        return w;
    endfunction

    // Queue one word for the FIFO and its expected appearance on the output.
    // seq marks a header inside an open event; fin marks footer W3.
    task automatic push_word(input logic [DW-1:0] w, input bit seq, input bit fin,
                             input bit em, input bit ew, input bit ec);
        rec_t e;
        src_q.push_back(w);
        if (fin) exp_evt = exp_evt + 32'd1;
        if ((seq || (fin && (em || ew || ec))) && exp_errc != 16'hFFFF) exp_errc = exp_errc + 16'd1;
        e.w = w;
        e.em = fin & em;
        e.ew = fin & ew;
        e.ec = fin & ec;
        e.seq = seq;
        e.evt = exp_evt;
        e.errc = exp_errc;
        exp_q.push_back(e);
    endtask

    task automatic add_body(input logic [39:0] l0id, input int nmeta, input int ndata, input bit seq);
        int m, d;
        push_word(mk_hdr(l0id), seq, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_l0id = l0id;
        m = nmeta;
        d = ndata;
        while (m + d > 0) begin
            if (m > 0 && (d == 0 || $urandom_range(0, 1) == 1)) begin
                push_word(mk_meta(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                m--;
            end else begin
                push_word(mk_data(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                d--;
            end
        end
    endtask

    // Header and meta words count toward the meta total; every body word counts
    // toward the word total.
    task automatic add_event(input logic [39:0] l0id, input int nmeta, input int ndata,
                             input logic [15:0] fmeta, input logic [31:0] fwc,
                             input logic [31:0] crc, input bit hdr_seq);
        bit em, ew, ec;
        add_body(l0id, nmeta, ndata, hdr_seq);
        em = (int'(fmeta) != nmeta + 1);
        ew = (fwc != 32'(nmeta + ndata + 1));
        ec = (crc != GOOD_CRC);
        push_word(mk_ftr1(fmeta), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_word(mk_data(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_word(mk_ftr3(fwc, crc), 1'b0, 1'b1, em, ew, ec);
    endtask

    task automatic begin_test();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        pop_cyc_q.delete();
        drop_base = drop_seq;
        stray_base = stray_err;
        exp_drop = 0;
    endtask

    task automatic drain(output bit ok);
        int unsigned n;
        n = 0;
        while ((src_q.size() != 0 || obs_q.size() < exp_q.size()) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        ok = (n < TMO);
        repeat (4) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        b2b_rst = 1'b1;
        src_q.push_back(mk_data());
        repeat (3) @(negedge clk);
        checks++;
        if ({out_event, out_wren, err_meta, err_word, err_crc, err_seq, evt_count, err_count, last_l0id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ev=%h wren=%b errs=%b%b%b%b evt=%0d errc=%0d l0id=%h, required all zero",
                     out_event, out_wren, err_meta, err_word, err_crc, err_seq, evt_count, err_count, last_l0id);
        end
        checks++;
        if (in_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_req: got %b required 0 (FIFO not empty)", in_req);
        end
        checks++;
        if (chk_id !== 8'd90) begin
            errors++;
            $display("FAIL chk_id: got %0d required 90", chk_id);
        end
        src_q.delete();
        repeat (2) @(negedge clk);
        b2b_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean();
        bit ok;
        rec_t got;
        begin_test();
        add_event(40'h123, 2, 5, 16'd3, 32'd8, GOOD_CRC, 1'b0);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clean_timeout: got %0d words required %0d", obs_q.size(), exp_q.size()); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clean_len: got %0d required %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : '0;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL clean_word%0d: got %h required %h", i, got, exp_q[i]); end
            checks++;
            if (i < obs_cyc_q.size() && i < pop_cyc_q.size() && obs_cyc_q[i] != pop_cyc_q[i] + 1) begin
                errors++;
                $display("FAIL clean_latency%0d: got %0d cycles required 1", i, obs_cyc_q[i] - pop_cyc_q[i]);
            end
        end
        checks++;
        if (evt_count !== 32'd1 || last_l0id !== 40'h123) begin
            errors++;
            $display("FAIL clean_status: got evt=%0d l0id=%h required evt=1 l0id=123", evt_count, last_l0id);
        end
        checks++;
        if (drop_seq - drop_base != 0 || stray_err != stray_base) begin
            errors++;
            $display("FAIL clean_stray: got drops=%0d stray=%0d required 0 0", drop_seq - drop_base, stray_err - stray_base);
        end
    endtask

    task automatic test_footer_errors();
        bit ok;
        rec_t got;
        for (int k = 0; k < 2; k++) begin
            begin_test();
            if (k == 0) add_event(40'h124, 2, 5, 16'd4, 32'd9, GOOD_CRC, 1'b0);
            else        add_event(40'h125, 2, 5, 16'd3, 32'd8, 32'h0, 1'b0);
            drain(ok);
            checks++;
            if (!ok || obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL ftrerr%0d_len: got %0d required %0d", k, obs_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                got = (i < obs_q.size()) ? obs_q[i] : '0;
                checks++;
                if (got !== exp_q[i]) begin errors++; $display("FAIL ftrerr%0d_word%0d: got %h required %h", k, i, got, exp_q[i]); end
            end
            checks++;
            if (err_count !== (k == 0 ? 16'd1 : 16'd2)) begin
                errors++;
                $display("FAIL ftrerr%0d_errcount: got %0d required %0d", k, err_count, k + 1);
            end
        end
    endtask

    task automatic test_drop();
        bit ok;
        rec_t got;
        begin_test();
        src_q.push_back(mk_data());
        src_q.push_back(mk_data());
        exp_drop = 2;
        add_event(40'h130, 1, 4, 16'd2, 32'd6, GOOD_CRC, 1'b0);
        drain(ok);
        checks++;
        if (drop_seq - drop_base != exp_drop) begin
            errors++;
            $display("FAIL drop_seq: got %0d pulses required %0d", drop_seq - drop_base, exp_drop);
        end
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL drop_len: got %0d required %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : '0;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL drop_word%0d: got %h required %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_hdr_in_body();
        bit ok;
        rec_t got;
        int seq_pulses;
        begin_test();
        add_body(40'h200, 1, 2, 1'b0);
        add_event(40'h201, 2, 3, 16'd3, 32'd6, GOOD_CRC, 1'b1);
        drain(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL hdrbody_len: got %0d required %0d", obs_q.size(), exp_q.size()); end
        seq_pulses = 0;
        foreach (obs_q[i]) seq_pulses += int'(obs_q[i].seq);
        checks++;
        if (seq_pulses != 1) begin errors++; $display("FAIL hdrbody_seqcount: got %0d required 1", seq_pulses); end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : '0;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL hdrbody_word%0d: got %h required %h", i, got, exp_q[i]); end
        end
        checks++;
        if (last_l0id !== 40'h201) begin errors++; $display("FAIL hdrbody_l0id: got %h required 201", last_l0id); end
    endtask

    task automatic test_random_stall();
        bit ok;
        rec_t got;
        int nm, nd;
        begin_test();
        af_toggle_en = 1'b1;
        for (int e = 0; e < 6; e++) begin
            nm = $urandom_range(0, 4);
            nd = $urandom_range(0, 12);
            add_event(40'(32'h400 + e), nm, nd,
                      16'(nm + 1 + (($urandom_range(0, 2) == 0) ? 1 : 0)),
                      32'(nm + nd + 1 + (($urandom_range(0, 2) == 0) ? 2 : 0)),
                      ($urandom_range(0, 3) == 0) ? $urandom : GOOD_CRC, 1'b0);
        end
        drain(ok);
        af_toggle_en = 1'b0;
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_len: got %0d required %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : '0;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL random_word%0d: got %h required %h", i, got, exp_q[i]); end
        end
        checks++;
        if (stray_err != stray_base || drop_seq != drop_base) begin
            errors++;
            $display("FAIL random_stray: got stray=%0d drops=%0d required 0 0", stray_err - stray_base, drop_seq - drop_base);
        end
    endtask

    task automatic test_reset_mid_event();
        bit ok;
        rec_t got;
        int unsigned n;
        int nout;
        begin_test();
        af_toggle_en = 1'b1;
        add_event(40'h300, 3, 10, 16'd4, 32'd14, GOOD_CRC, 1'b0);
        n = 0;
        while (obs_q.size() < 5 && n < TMO) begin @(negedge clk); n++; end
        b2b_rst = 1'b1;
        src_q.delete();
        af_toggle_en = 1'b0;
        repeat (3) @(negedge clk);
        nout = obs_q.size();
        checks++;
        if (n >= TMO || nout < 5 || nout >= exp_q.size()) begin
            errors++;
            $display("FAIL rstmid_prefix_len: got %0d words required 5..%0d", nout, exp_q.size() - 1);
        end
        for (int i = 0; i < nout && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if ({out_event, out_wren, err_meta, err_word, err_crc, err_seq, evt_count, err_count, last_l0id, in_req} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got ev=%h wren=%b evt=%0d errc=%0d l0id=%h req=%b required all zero",
                     out_event, out_wren, evt_count, err_count, last_l0id, in_req);
        end
        checks++;
        if (stray_err != stray_base || drop_seq != drop_base) begin
            errors++;
            $display("FAIL rstmid_pulse: got stray=%0d drops=%0d required 0 0", stray_err - stray_base, drop_seq - drop_base);
        end
        b2b_rst = 1'b0;
        exp_evt = '0;
        exp_errc = '0;
        exp_l0id = '0;
        @(negedge clk);

        begin_test();
        add_event(40'h301, 1, 2, 16'd2, 32'd4, GOOD_CRC, 1'b0);
        drain(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rstpost_len: got %0d required %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            got = (i < obs_q.size()) ? obs_q[i] : '0;
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL rstpost_word%0d: got %h required %h", i, got, exp_q[i]); end
        end
        checks++;
        if (evt_count !== 32'd1 || err_count !== 16'd0 || last_l0id !== 40'h301 || drop_seq != drop_base) begin
            errors++;
            $display("FAIL rstpost_status: got evt=%0d errc=%0d l0id=%h drops=%0d required 1 0 301 0",
                     evt_count, err_count, last_l0id, drop_seq - drop_base);
        end
    endtask

    initial begin
        b2b_rst = 1'b1;
        test_reset();
        test_clean();
        test_footer_errors();
        test_drop();
        test_hdr_in_body();
        test_random_stall();
        test_reset_mid_event();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
